// File: rtl/dm_write_buffer_pkg.sv
// Shared types and constants for the data-memory write buffer.
package dm_write_buffer_pkg;

    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_AW    = 32;
    localparam int MAX_AW        = 32;
    localparam int STRB_W        = 4;
    localparam int DATA_W        = 32;

    // One buffered store. The word address is held at the widest supported
    // width; narrower AW configurations use only the low AW-2 bits.
    typedef struct packed {
        logic [MAX_AW-3:0] addr;
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/dm_write_buffer_wb_fifo.sv
// Store FIFO: entry storage, wrapping pointers, occupancy count and a
// per-entry word-address compare vector used for load hazard detection.
module wb_fifo
    import dm_write_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  wb_entry_t                 push_entry,
    input  logic                      pop,
    input  logic [AW-3:0]             match_addr,
    output wb_entry_t                 head,
    output logic [$clog2(DEPTH):0]    count,
    output logic [DEPTH-1:0]          match,
    output logic                      empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    wb_entry_t        slots [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign do_push = push && (count != FULL_CNT);
    assign do_pop  = pop  && (count != '0);
    assign head    = slots[rd_ptr];

    // Next occupancy; a simultaneous push and pop cancel out.
    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CNT_ONE;
        end else if (!do_push && do_pop) begin
            count_next = count - CNT_ONE;
        end
    end

    // Control state: pointers, count, valid bits and the registered empty flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
            empty  <= 1'b1;
        end else begin
            if (do_pop) begin
                rd_ptr        <= rd_ptr + PTR_ONE;
                valid[rd_ptr] <= 1'b0;
            end
            if (do_push) begin
                wr_ptr        <= wr_ptr + PTR_ONE;
                valid[wr_ptr] <= 1'b1;
            end
            count <= count_next;
            empty <= (count_next == '0);
        end
    end

    // Entry payload storage; no reset needed since valid bits qualify it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_entry;
        end
    end

    // Word-address compare against every live entry (pre-edge state, so the
    // entry being written this cycle never participates).
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid[i] && (slots[i].addr[AW-3:0] == match_addr);
        end
    end

endmodule

// File: rtl/dm_write_buffer.sv
// Data-memory write buffer: posts CPU stores into a FIFO and drains them to
// the single-ported data SRAM whenever a load is not using the port. Loads
// that hit a buffered store stall until the matching entries have drained.
module dm_write_buffer
    import dm_write_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_read,
    input  logic [STRB_W-1:0] cpu_write,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_read,
    output logic [STRB_W-1:0] mem_write,
    output logic [AW-1:0]     mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              empty
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    wb_entry_t        entry_in;
    wb_entry_t        head;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] match;
    logic             store_req;
    logic             full_stall;
    logic             hz;
    logic             load_go;
    logic             drain;
    logic             push;

    wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (entry_in),
        .pop        (drain),
        .match_addr (cpu_addr[AW-1:2]),
        .head       (head),
        .count      (count),
        .match      (match),
        .empty      (empty)
    );

    // Load data is a straight pass-through so load timing is unchanged.
    assign cpu_rdata = mem_rdata;

    // Pack the incoming store into a FIFO entry.
    always_comb begin
        entry_in           = '0;
        entry_in.addr[AW-3:0] = cpu_addr[AW-1:2];
        entry_in.strb      = cpu_write;
        entry_in.data      = cpu_wdata;
    end

    // Request decode and port arbitration: loads win, drains fill idle slots.
    // Store acceptance is judged on the start-of-cycle count, so a drain in
    // the same cycle does not free room for a store while full.
    always_comb begin
        store_req  = (cpu_write != '0);
        full_stall = !rst && store_req && (count == FULL_CNT);
        push       = !rst && store_req && (count != FULL_CNT);
        hz         = !rst && cpu_read && (match != '0);
        load_go    = !rst && cpu_read && !hz;
        drain      = !rst && !load_go && (count != '0);
        cpu_stall  = full_stall || hz;
    end

    // SRAM port drive; address and data are zero whenever the port is idle.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (load_go) begin
            mem_read = 1'b1;
            mem_addr = cpu_addr;
        end else if (drain) begin
            mem_write = head.strb;
            mem_addr  = {head.addr[AW-3:0], 2'b00};
            mem_wdata = head.data;
        end
    end

endmodule

// File: tb/tb_dm_write_buffer.sv
// Self-checking bench for dm_write_buffer: directed scenarios plus random
// traffic, all compared cycle by cycle against a queue-based reference model.
module tb_dm_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic        clk;
    logic        rst;
    logic        cpu_read;
    logic [3:0]  cpu_write;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_read;
    logic [3:0]  mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        empty;

    dm_write_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: pending stores in order, and two SRAM images
    // (one written by the model's rules, one by what the DUT actually drives).
    typedef struct {
        logic [29:0] a;
        logic [3:0]  s;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic [31:0] ref_sram [16];
    logic [31:0] dut_sram [16];

    assign mem_rdata = mem_read ? dut_sram[mem_addr[5:2]] : 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        foreach (q[i]) begin
            if (q[i].a == a[31:2]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock cycle: drive inputs, check every output against the model at
    // the falling edge, then advance the model as the rising edge will.
    task automatic step(input logic rd, input logic [3:0] wr, input logic [31:0] a,
                        input logic [31:0] d, output logic stall_exp);
        logic        hz, full, drn;
        logic        er;
        logic [3:0]  ew;
        logic [31:0] ea, ed;
        int          n0;
        cpu_read = rd; cpu_write = wr; cpu_addr = a; cpu_wdata = d;
        @(negedge clk);
        n0   = q.size();
        hz   = rd && model_hit(a);
        full = (wr != 4'h0) && (n0 == DEPTH);
        drn  = 1'b0;
        er = 1'b0; ew = 4'h0; ea = 32'h0; ed = 32'h0;
        if (rd && !hz) begin
            er = 1'b1; ea = a;
        end else if (n0 > 0) begin
            drn = 1'b1; ew = q[0].s; ea = {q[0].a, 2'b00}; ed = q[0].d;
        end
        stall_exp = hz || full;
        chk("mem_read",  mem_read,  er);
        chk("mem_write", mem_write, ew);
        chk("mem_addr",  mem_addr,  ea);
        chk("mem_wdata", mem_wdata, ed);
        chk("cpu_stall", cpu_stall, stall_exp);
        chk("empty",     empty,     n0 == 0);
        if (er) chk("cpu_rdata", cpu_rdata, ref_sram[a[5:2]]);
        if (mem_write != 4'h0)
            dut_sram[mem_addr[5:2]] = merge(dut_sram[mem_addr[5:2]], mem_wdata, mem_write);
        if (drn) begin
            ref_sram[q[0].a[3:0]] = merge(ref_sram[q[0].a[3:0]], q[0].d, q[0].s);
            void'(q.pop_front());
        end
        if ((wr != 4'h0) && (n0 < DEPTH)) q.push_back('{a: a[31:2], s: wr, d: d});
        @(posedge clk);
        #1;
    endtask

    // CPU-style request: held until the cycle in which it is not stalled.
    task automatic cpu_op(input logic rd, input logic [3:0] wr, input logic [31:0] a,
                          input logic [31:0] d);
        logic st;
        int   n;
        n = 0;
        do begin
            step(rd, wr, a, d, st);
            n++;
        end while (st && n < 40);
        chk("stall_released", st, 1'b0);
    endtask

    task automatic idle(input int cycles);
        logic st;
        for (int i = 0; i < cycles; i++) step(1'b0, 4'h0, 32'h0, 32'h0, st);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_read"},  mem_read,  1'b0);
        chk({tag, "_mem_write"}, mem_write, 4'h0);
        chk({tag, "_mem_addr"},  mem_addr,  32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_cpu_stall"}, cpu_stall, 1'b0);
        chk({tag, "_empty"},     empty,     1'b1);
    endtask

    // Asynchronous reset mid-cycle with requests active; buffered stores die.
    task automatic reset_pulse(input string tag);
        cpu_read = 1'b1; cpu_write = 4'hF; cpu_addr = 32'h8008; cpu_wdata = 32'hCAFEF00D;
        #2 rst = 1'b1;
        #1 chk_reset_outputs(tag);
        q.delete();
        @(posedge clk);
        #1;
        cpu_read = 1'b0; cpu_write = 4'h0;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          kind;
        logic [31:0] a, d;
        logic [3:0]  s;
        logic        rd;

        for (int i = 0; i < 16; i++) begin
            ref_sram[i] = $urandom;
            dut_sram[i] = ref_sram[i];
        end

        // Reset held with requests present: everything must stay quiet.
        rst = 1'b1;
        cpu_read = 1'b1; cpu_write = 4'hF; cpu_addr = 32'h8000; cpu_wdata = 32'h1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("por");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cpu_read = 1'b0; cpu_write = 4'h0;

        // Single store drains the following cycle.
        cpu_op(1'b0, 4'hF, 32'h8000, 32'hDEADBEEF);
        idle(2);

        // Fill to DEPTH using loads that keep the port busy, then a plain store
        // that must stall exactly while the FIFO is full.
        for (int i = 0; i < DEPTH; i++)
            cpu_op(1'b1, 4'hF, 32'h8010 + 32'(4 * i), 32'h1000_0000 + 32'(i));
        cpu_op(1'b0, 4'hF, 32'h8020, 32'h2000_0005);
        idle(DEPTH + 2);

        // Store then load to the same word: stall while it drains, then read.
        cpu_op(1'b0, 4'hF, 32'h8004, 32'h1234_5678);
        cpu_op(1'b1, 4'h0, 32'h8004, 32'h0);
        idle(1);

        // Non-matching load with stores pending goes straight through.
        cpu_op(1'b1, 4'hF, 32'h8028, 32'hA5A5_0001);
        cpu_op(1'b0, 4'hF, 32'h802C, 32'hA5A5_0002);
        cpu_op(1'b1, 4'h0, 32'h9000, 32'h0);
        idle(3);

        // Reset with three stores buffered discards them.
        for (int i = 0; i < 3; i++)
            cpu_op(1'b1, 4'hF, 32'h8034 + 32'(4 * i), 32'hBAD0_0000 + 32'(i));
        reset_pulse("midrst");
        idle(2);

        // Single-byte store.
        cpu_op(1'b0, 4'b0010, 32'h8030, 32'h0000_AB00);
        idle(2);

        // Random traffic over a small address window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) reset_pulse("rndrst");
            kind = $urandom_range(0, 9);
            a = 32'h8000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            d = $urandom;
            s = 4'($urandom_range(1, 15));
            if (kind < 3) begin
                idle(1);
            end else if (kind < 7) begin
                cpu_op(1'b0, s, a, d);
            end else if (kind < 9) begin
                cpu_op(1'b1, 4'h0, a, 32'h0);
            end else begin
                // Combined load+store only where holding it cannot livelock.
                rd = !model_hit(a) && (q.size() < DEPTH);
                cpu_op(rd, s, a, d);
            end
        end

        // Drain everything and compare the final SRAM images word by word.
        for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
        idle(2);
        for (int i = 0; i < 16; i++) chk($sformatf("sram[%0d]", i), dut_sram[i], ref_sram[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dm_write_buffer.md
DM_WRITE_BUFFER -- requirements
Module: dm_write_buffer

Interface
REQ-001 Parameter: DEPTH, 4, number of buffered store entries (power of two, 2..16).
REQ-002 Parameter: AW, 32, address width on both ports.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cpu_read  in  1  CPU load request.
REQ-006 cpu_write  in  4  CPU store byte strobes; nonzero means store.
REQ-007 cpu_addr  in  AW  CPU byte address; bits [1:0] are ignored for matching.
REQ-008 cpu_wdata  in  32  CPU store data.
REQ-009 cpu_rdata  out  32  load data to the CPU.
REQ-010 cpu_stall  out  1  CPU holds its request and PC while this is high.
REQ-011 mem_read  out  1  data SRAM read enable.
REQ-012 mem_write  out  4  data SRAM byte write strobes.
REQ-013 mem_addr  out  AW  data SRAM byte address.
REQ-014 mem_wdata  out  32  data SRAM write data.
REQ-015 mem_rdata  in  32  data SRAM read data.
REQ-016 empty  out  1  high when no store is buffered.

Function
REQ-017 The block SHALL hold a FIFO of DEPTH entries {addr[AW-1:2], strb[3:0], data[31:0]}, with read/write pointers that wrap modulo DEPTH and a count of 0..DEPTH.
REQ-018 Store accept: if cpu_write!=0 and count<DEPTH at cycle start, the store SHALL be enqueued at the edge; stores are not coalesced.
REQ-019 Full: if cpu_write!=0 and count==DEPTH, cpu_stall SHALL be 1 and nothing is enqueued, even if a drain occurs in the same cycle.
REQ-020 Hazard: hz=1 when cpu_read=1 and any valid entry's addr equals cpu_addr[AW-1:2]; the entry being enqueued in the same cycle is excluded.
REQ-021 Port arbitration, one SRAM operation per cycle, in priority order:
  - cpu_read=1 and hz=0 -> mem_read=1, mem_addr=cpu_addr, mem_write=0.
  - otherwise, if count>0 -> drain the head entry: mem_write=strb, mem_addr={addr,2'b00}, mem_wdata=data; dequeue at the edge.
  - otherwise -> mem_read=0 and mem_write=0.
REQ-022 While hz=1, cpu_stall SHALL be 1 and draining continues; the load is issued in the first cycle hz clears.
REQ-023 cpu_rdata SHALL equal mem_rdata combinationally, so load timing matches a direct CPU-to-SRAM connection.
REQ-024 cpu_stall SHALL be the OR of the full condition and hz; it is combinational and has no registered delay.
REQ-025 Simultaneous enqueue and dequeue SHALL leave count unchanged; entries drain in strict FIFO order.
REQ-026 When cpu_read and cpu_write are both asserted, the read and the enqueue SHALL both be evaluated independently per REQ-018..REQ-022.
REQ-027 empty SHALL equal (count==0), registered from state.
REQ-028 Idle outputs: mem_addr and mem_wdata are 0 when no SRAM operation is issued.

Reset
REQ-029 While rst is high: count, pointers, all entry valid bits, mem_read, mem_write, mem_addr, mem_wdata and cpu_stall are 0, and empty is 1.
REQ-030 rst asserted mid-operation SHALL discard all buffered stores without writing them to the SRAM.
REQ-031 In the first cycle after rst deasserts, the block SHALL accept requests.

Structure
REQ-032 A shared package SHALL hold the entry struct typedef, the default DEPTH, and the strobe-width constant (4).
REQ-033 The block SHALL contain one sub-module, wb_fifo (storage, pointers, count, per-entry address compare vector); arbitration is top-level logic.

Verification
REQ-034 Store 0xDEADBEEF, strb 4'hF, address 0x8000, then idle -> mem_write=4'hF with that address and data one cycle later; empty=1 afterwards.
REQ-035 5 back-to-back stores with DEPTH=4 and no loads -> cpu_stall=1 on the 5th store only while count==4; all 5 reach the SRAM in order.
REQ-036 Store to 0x8004 followed immediately by a load from 0x8004 -> cpu_stall=1 for 1 cycle while the drain completes, then mem_read=1 and cpu_rdata equals the stored value.
REQ-037 Two buffered stores, then a load from non-matching address 0x9000 -> load issued the same cycle with no stall; drains resume after it.
REQ-038 rst pulsed with 3 entries buffered -> no mem_write is issued, empty=1, and SRAM contents are unchanged.
REQ-039 Byte store with strb 4'b0010 and data 0x0000AB00 -> mem_write=4'b0010 with only that byte lane's data significant.
